// File: rtl/viterbi_ber_monitor.sv
// viterbi_ber_monitor: locks to decoder latency against a reference tap and counts residual bit errors.
// Optional first-error capture is built only when BER_MON_FIRST_ERR_EN is defined.
module viterbi_ber_monitor #(
    parameter int MAX_LAT  = 64,
    parameter int WIN      = 32,
    parameter int LOCK_THR = 2,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ref_valid_i,
    input  logic                       ref_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] lat_o,
    output logic                       lost_o,
    output logic [CNT_W-1:0]           bit_ct_o,
    output logic [CNT_W-1:0]           err_ct_o,
    output logic [CNT_W-1:0]           first_err_o,
    output logic                       first_err_vld_o
);
    localparam int LW = $clog2(MAX_LAT);
    localparam int WW = $clog2(WIN + 2);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [MAX_LAT-1:0] h_q;
    logic [LW-1:0]      lat_q, lat_d;
    logic [WW-1:0]      wcnt_q, wcnt_d, wmiss_q, wmiss_d, wtot;
    logic [CNT_W-1:0]   bit_q, bit_d, err_q, err_d;
    logic               lost_q, lost_d, miss, wend;

    assign miss = dec_bit_i ^ h_q[lat_q];
    assign wtot = wmiss_q + WW'(miss);
    assign wend = wcnt_q == WW'(WIN - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q     <= '0;
            state_q <= SEARCH;
            lat_q   <= '0;
            wcnt_q  <= '0;
            wmiss_q <= '0;
            bit_q   <= '0;
            err_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            if (ref_valid_i) h_q <= {h_q[MAX_LAT-2:0], ref_bit_i};
            state_q <= state_d;
            lat_q   <= lat_d;
            wcnt_q  <= wcnt_d;
            wmiss_q <= wmiss_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    // The window-completing bit is counted in LOCKED before any loss decision.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        wcnt_d  = wcnt_q;
        wmiss_d = wmiss_q;
        bit_d   = bit_q;
        err_d   = err_q;
        lost_d  = 1'b0;
        if (dec_valid_i) begin
            wcnt_d  = wend ? '0 : wcnt_q + 1'b1;
            wmiss_d = wend ? '0 : wtot;
            if (state_q == LOCKED) begin
                bit_d = &bit_q ? bit_q : bit_q + 1'b1;
                err_d = (miss && !(&err_q)) ? err_q + 1'b1 : err_q;
                if (wend && wtot >= WW'(LOSS_THR)) begin
                    state_d = SEARCH;
                    lat_d   = '0;
                    lost_d  = 1'b1;
                end
            end else if (wend) begin
                state_d = wtot <= WW'(LOCK_THR) ? LOCKED : SEARCH;
                lat_d   = wtot <= WW'(LOCK_THR) ? lat_q :
                          lat_q == LW'(MAX_LAT - 1) ? '0 : lat_q + 1'b1;
            end
        end
        if (clear_i) begin
            bit_d = '0;
            err_d = '0;
        end
    end

    assign locked_o = state_q == LOCKED;
    assign lat_o    = lat_q;
    assign lost_o   = lost_q;
    assign bit_ct_o = bit_q;
    assign err_ct_o = err_q;

`ifdef BER_MON_FIRST_ERR_EN
    logic [CNT_W-1:0] fe_q, fe_d;
    logic             fe_vld_q, fe_vld_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fe_q     <= '0;
            fe_vld_q <= 1'b0;
        end else begin
            fe_q     <= fe_d;
            fe_vld_q <= fe_vld_d;
        end
    end

    always_comb begin
        fe_d     = fe_q;
        fe_vld_d = fe_vld_q;
        if (dec_valid_i && miss && state_q == LOCKED && !fe_vld_q) begin
            fe_d     = bit_q;
            fe_vld_d = 1'b1;
        end
        if (clear_i) begin
            fe_d     = '0;
            fe_vld_d = 1'b0;
        end
    end

    assign first_err_o     = fe_q;
    assign first_err_vld_o = fe_vld_q;
`else
    assign first_err_o     = '0;
    assign first_err_vld_o = 1'b0;
`endif

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// tb_viterbi_ber_monitor: directed checks of lock search, error counting, loss, clear,
// saturation (second instance with CNT_W=4) and async reset.
module tb_viterbi_ber_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ref_valid_i = 1'b0, ref_bit_i = 1'b0;
    logic       dec_valid_i = 1'b0, dec_bit_i = 1'b0, clear_i = 1'b0;

    logic        locked_a, lost_a, fev_a;
    logic [5:0]  lat_a;
    logic [31:0] bit_a, err_a, fe_a;
    logic        locked_b, lost_b, fev_b;
    logic [5:0]  lat_b;
    logic [3:0]  bit_b, err_b, fe_b;

    int checks = 0;
    int failures = 0;
    int lost_seen = 0;
    logic [6:0]  prbs = 7'h7F;
    logic [15:0] hist = '0;

    always #5 clk = ~clk;

    viterbi_ber_monitor u_dut (
        .clk(clk), .rst(rst),
        .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
        .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .clear_i(clear_i),
        .locked_o(locked_a), .lat_o(lat_a), .lost_o(lost_a),
        .bit_ct_o(bit_a), .err_ct_o(err_a),
        .first_err_o(fe_a), .first_err_vld_o(fev_a)
    );

    viterbi_ber_monitor #(.CNT_W(4), .LOSS_THR(33)) u_sat (
        .clk(clk), .rst(rst),
        .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
        .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i), .clear_i(clear_i),
        .locked_o(locked_b), .lat_o(lat_b), .lost_o(lost_b),
        .bit_ct_o(bit_b), .err_ct_o(err_b),
        .first_err_o(fe_b), .first_err_vld_o(fev_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Decoded bit is the reference from 11 cycles back, which sits at h[10] in the DUT.
    task automatic cyc(input logic dv, input logic flip, input logic clr);
        logic nb;
        nb = prbs[6] ^ prbs[5];
        prbs = {prbs[5:0], nb};
        ref_valid_i = 1'b1;
        ref_bit_i   = nb;
        dec_valid_i = dv;
        dec_bit_i   = hist[10] ^ flip;
        clear_i     = clr;
        @(posedge clk);
        @(negedge clk);
        hist = {hist[14:0], nb};
        if (lost_a) lost_seen++;
    endtask

    task automatic relock(input string tag);
        int n;
        n = 0;
        while (!locked_a && n < 400) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk({tag, "_locked"}, 32'(locked_a), 32'd1);
        chk({tag, "_lat"}, 32'(lat_a), 32'd10);
        chk({tag, "_full_search"}, 32'(n > 320 && n <= 352), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked_a), 32'd0);
        chk("rst_lat", 32'(lat_a), 32'd0);
        chk("rst_lost", 32'(lost_a), 32'd0);
        chk("rst_bit", bit_a, 32'd0);
        chk("rst_err", err_a, 32'd0);
        chk("rst_fev", 32'(fev_a), 32'd0);
        rst = 1'b1;

        // 1: initial lock at lat 10
        repeat (16) cyc(1'b0, 1'b0, 1'b0);
        relock("t1");
        chk("t1_sat_locked", 32'(locked_b), 32'd1);
        chk("t1_bit0", bit_a, 32'd0);
        chk("t1_err0", err_a, 32'd0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0);
        chk("t1_bit5", bit_a, 32'd5);
        chk("t1_err5", err_a, 32'd0);

        // 2: sparse errors, lock retained
        cyc(1'b1, 1'b0, 1'b1);
        chk("t2_clr_bit", bit_a, 32'd0);
        lost_seen = 0;
        for (int i = 0; i < 1000; i++) cyc(1'b1, i % 100 == 50, 1'b0);
        chk("t2_bit", bit_a, 32'd1000);
        chk("t2_err", err_a, 32'd10);
        chk("t2_locked", 32'(locked_a), 32'd1);
        chk("t2_no_lost", 32'(lost_seen), 32'd0);
        chk("t2_sat_bit", 32'(bit_b), 32'd15);
`ifdef BER_MON_FIRST_ERR_EN
        chk("t2_fe", fe_a, 32'd50);
        chk("t2_fev", 32'(fev_a), 32'd1);
`else
        chk("t2_fe_tied", fe_a, 32'd0);
        chk("t2_fev_tied", 32'(fev_a), 32'd0);
`endif

        // 3: burst of 12 at window positions 14..25; window closes 18 bits later
        for (int i = 0; i < 18; i++) cyc(1'b1, i < 12, 1'b0);
        chk("t3_lost", 32'(lost_a), 32'd1);
        chk("t3_unlocked", 32'(locked_a), 32'd0);
        chk("t3_lat0", 32'(lat_a), 32'd0);
        chk("t3_bit", bit_a, 32'd1018);
        chk("t3_err", err_a, 32'd22);
        cyc(1'b1, 1'b0, 1'b0);
        chk("t3_lost_pulse", 32'(lost_a), 32'd0);
        chk("t3_lost_once", 32'(lost_seen), 32'd1);
        relock("t3");
        chk("t3_hold_bit", bit_a, 32'd1018);
        chk("t3_hold_err", err_a, 32'd22);

        // 4: clear wins over a same-cycle mismatch
        cyc(1'b1, 1'b1, 1'b1);
        chk("t4_err", err_a, 32'd0);
        chk("t4_bit", bit_a, 32'd0);
        chk("t4_fev", 32'(fev_a), 32'd0);
        chk("t4_locked", 32'(locked_a), 32'd1);
        chk("t4_sat_err", 32'(err_b), 32'd0);

        // 5: saturation on the 4-bit instance
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (14) cyc(1'b1, 1'b1, 1'b0);
        chk("t5_err14", 32'(err_b), 32'd14);
        chk("t5_bit15", 32'(bit_b), 32'd15);
        repeat (6) cyc(1'b1, 1'b1, 1'b0);
        chk("t5_err_sat", 32'(err_b), 32'd15);
        chk("t5_bit_sat", 32'(bit_b), 32'd15);
        chk("t5_locked", 32'(locked_b), 32'd1);
`ifdef BER_MON_FIRST_ERR_EN
        chk("t5_fe", 32'(fe_b), 32'd3);
        chk("t5_fev", 32'(fev_b), 32'd1);
`else
        chk("t5_fev_tied", 32'(fev_b), 32'd0);
`endif

        // 6: async reset between edges
        #2 rst = 1'b0;
        #1;
        chk("t6_locked", 32'(locked_b), 32'd0);
        chk("t6_lat", 32'(lat_b), 32'd0);
        chk("t6_bit", 32'(bit_b), 32'd0);
        chk("t6_err", 32'(err_b), 32'd0);
        chk("t6_lost", 32'(lost_b), 32'd0);
        chk("t6_a_bit", bit_a, 32'd0);
        chk("t6_a_lat", 32'(lat_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (16) cyc(1'b0, 1'b0, 1'b0);
        relock("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
